spi_slave_full: RTL and testbench
=================================

Name: spi_slave_full

Overview:
- Byte-oriented SPI slave, full duplex, clocked directly by the SPI serial clock `sclk`.
- Each frame is started by a one-cycle `ss` strobe. Per frame the block shifts one parallel transmit byte out on `miso` and assembles one byte from `mosi`.
- On frame completion it presents the received byte to the local logic with a one-cycle ready pulse.
- Sits between the pad-level SPI pins and the local register/buffer logic.

Parameters:
- DATA_W, 8, bits per frame; also the width of `outbuf` and `buffer_in`.

Ports:
- sclk  input  1  SPI serial clock; the only clock; all state changes on its rising edge.
- rst  input  1  reset: one clock; reset is synchronous and active-high.
- ss  input  1  frame-start strobe, active-high, sampled on the rising edge; high for exactly one cycle per frame.
- mosi  input  1  serial data in, sampled on the rising edge.
- miso  output  1  serial data out (combinational, see Behaviour).
- outbuf  input  DATA_W  byte to transmit; must be valid at the edge where `ss`=1.
- read  output  1  one-cycle pulse: `outbuf` was captured for transmission.
- buffer_in  output  DATA_W  last completely received byte; holds until the next completion.
- ready_in  output  1  one-cycle pulse: `buffer_in` was just updated.

Behaviour:
- State registers:
  - tx_shift[DATA_W-1:0]
  - rx_shift[DATA_W-2:0]
  - bit counter cnt, 0..DATA_W-1
  - active flag
- Reset (`rst`=1 at a rising edge), which has priority over everything else, clears:
  - tx_shift, rx_shift, cnt and active
  - `buffer_in`=0, `ready_in`=0, `read`=0
  - `miso` then reads 0 unless `ss`=1.
- `miso` = `ss` ? outbuf[DATA_W-1] : tx_shift[DATA_W-1]. The first bit is therefore on the wire during the strobe cycle itself.
- Frame edge 0 (rising edge with `ss`=1, not in reset):
  - tx_shift <= outbuf shifted left one bit, zero filled.
  - rx_shift <= {.., mosi}: the first received bit goes into the LSB.
  - cnt <= 1; active <= 1; read <= 1.
- Frame edges 1..DATA_W-1 (active=1, `ss`=0):
  - rx_shift takes mosi in at the LSB.
  - tx_shift shifts left with zero fill.
  - cnt increments.
- Edge DATA_W-1 completes the frame:
  - buffer_in <= {rx_shift, mosi}; the first bit received becomes the MSB.
  - ready_in <= 1; active <= 0; cnt <= 0.
- `read` and `ready_in` are high for exactly one cycle and cleared on the following edge.
- Back-to-back frames: `ss` may be high on the edge immediately after a completing edge. Frames of exactly DATA_W cycles are supported with no gap. `ready_in` from frame N overlaps edge 0 of frame N+1.
- `ss`=1 while active (mid-frame restart):
  - The partial frame is discarded: no `ready_in`, `buffer_in` unchanged.
  - A new frame starts per edge 0.
- Idle (active=0, `ss`=0): no state changes. tx_shift has been shifted to zero, so `miso`=0.
- Reset mid-frame aborts the frame with no `ready_in`.
- Loopback (`mosi` tied to `miso`): `buffer_in` equals the `outbuf` captured at that frame's edge 0.

Optional Feature:
- Macro SPI_SLAVE_LSB_FIRST_EN.
- When defined:
  - Bit order is LSB first.
  - `miso` = `ss` ? outbuf[0] : tx_shift[0], and tx_shifts right with zero fill.
  - Received bits enter at the MSB side, so the first bit received becomes buffer_in[0].
  - Framing, timing and strobes are identical to the undefined case.
- When undefined: MSB first, as above.
- Loopback equality holds in both modes.

Test Plan:
- Reset and idle: hold `rst` 2 cycles, then `ss`=0 for 4 cycles -> `miso`=0, `buffer_in`=8'h00, `ready_in` and `read` never asserted.
- Loopback, back-to-back: `mosi`=`miso`; frames of 8 cycles with `outbuf`=A5, 5A, AA, CC, 0F, F0 -> `read` pulses at each edge 0. `ready_in` pulses once per frame, one cycle after edge 7, with `buffer_in` = A5, 5A, AA, CC, 0F, F0 in order.
- Serial check: `outbuf`=A5 -> `miso` sequence over edges 0..7 is 1,0,1,0,0,1,0,1, with `miso`=0 after the frame.
- Mid-frame restart: start a frame with 3C, reassert `ss` at edge 4 with `outbuf`=C3 -> no `ready_in` for 3C; `buffer_in`=C3 after 8 further edges.
- Reset mid-frame: `rst`=1 at edge 5 of a frame with 81 -> `ready_in` stays 0, `buffer_in`=00, and the next full frame with 7E returns 7E.
- With SPI_SLAVE_LSB_FIRST_EN: `outbuf`=01 -> `miso`=1 on edge 0 then 0, and loopback `buffer_in`=01.

Source files
------------

// File: rtl/spi_slave_full.sv
// Byte-oriented full-duplex SPI slave clocked by sclk; one ss strobe starts each frame.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first bit order (default MSB first).
module spi_slave_full #(
  parameter int DATA_W = 8
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] outbuf,
  output logic              read,
  output logic [DATA_W-1:0] buffer_in,
  output logic              ready_in
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q, active_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              ready_q, ready_d;
  logic              read_q, read_d;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  function automatic logic [DATA_W-1:0] tx_next(input logic [DATA_W-1:0] v);
    return v >> 1;
  endfunction
  function automatic logic [DATA_W-2:0] rx_next(input logic [DATA_W-2:0] v, input logic b);
    return {b, v[DATA_W-2:1]};
  endfunction
  function automatic logic [DATA_W-1:0] rx_full(input logic [DATA_W-2:0] v, input logic b);
    return {b, v};
  endfunction
  assign miso = ss ? outbuf[0] : tx_q[0];
`else
  function automatic logic [DATA_W-1:0] tx_next(input logic [DATA_W-1:0] v);
    return v << 1;
  endfunction
  function automatic logic [DATA_W-2:0] rx_next(input logic [DATA_W-2:0] v, input logic b);
    return {v[DATA_W-3:0], b};
  endfunction
  function automatic logic [DATA_W-1:0] rx_full(input logic [DATA_W-2:0] v, input logic b);
    return {v, b};
  endfunction
  assign miso = ss ? outbuf[DATA_W-1] : tx_q[DATA_W-1];
`endif

  // A strobe always restarts the frame, discarding any partial byte in flight.
  always_comb begin
    tx_d     = tx_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    buf_d    = buf_q;
    ready_d  = 1'b0;
    read_d   = 1'b0;
    if (ss) begin
      tx_d     = tx_next(outbuf);
      rx_d     = rx_next(rx_q, mosi);
      cnt_d    = CNT_W'(1);
      active_d = 1'b1;
      read_d   = 1'b1;
    end else if (active_q) begin
      tx_d = tx_next(tx_q);
      rx_d = rx_next(rx_q, mosi);
      if (cnt_q == LAST) begin
        buf_d    = rx_full(rx_q, mosi);
        ready_d  = 1'b1;
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      tx_q     <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      buf_q    <= '0;
      ready_q  <= 1'b0;
      read_q   <= 1'b0;
    end else begin
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      buf_q    <= buf_d;
      ready_q  <= ready_d;
      read_q   <= read_d;
    end
  end

  assign buffer_in = buf_q;
  assign ready_in  = ready_q;
  assign read      = read_q;

endmodule

// File: tb/tb_spi_slave_full.sv
// Randomized scoreboard bench for spi_slave_full; bit order follows SPI_SLAVE_LSB_FIRST_EN.
module tb_spi_slave_full;

  logic       sclk = 1'b0;
  logic       rst, ss, mosi;
  logic       miso, read, ready_in;
  logic [7:0] outbuf, buffer_in;

  spi_slave_full #(.DATA_W(8)) dut (
    .sclk(sclk), .rst(rst), .ss(ss), .mosi(mosi), .miso(miso),
    .outbuf(outbuf), .read(read), .buffer_in(buffer_in), .ready_in(ready_in)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [7:0] val;
    int         edge_idx;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   edge_n = 0;
  logic ss_smp, rst_smp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Position in outbuf of the k-th bit on the wire.
  function automatic int bitpos(input int k);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return k;
`else
    return 7 - k;
`endif
  endfunction

  // Monitor: strobes and received bytes checked a little after each rising edge.
  always @(posedge sclk) begin
    edge_n++;
    ss_smp  = ss;
    rst_smp = rst;
    #2;
    chk("read", read, ss_smp && !rst_smp);
    if (ready_in) begin
      if (q.size() == 0) begin
        chk("ready_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("buffer_in", buffer_in, e.val);
        chk("ready_edge", edge_n, e.edge_idx);
      end
    end else if (q.size() > 0 && q[0].edge_idx == edge_n) begin
      chk("ready_missing", 0, 1);
      void'(q.pop_front());
    end
  end

  task automatic drive_frame(input logic [7:0] ob, input int n, input bit loop,
                             input logic [7:0] mb, input bit push);
    for (int k = 0; k < n; k++) begin
      @(negedge sclk);
      rst    = 1'b0;
      ss     = (k == 0);
      outbuf = (k == 0) ? ob : 8'($urandom);
      #1;
      chk("miso", miso, ob[bitpos(k)]);
      mosi = loop ? miso : mb[bitpos(k)];
      if (k == 0 && push) begin
        exp_t e;
        e.val      = loop ? ob : mb;
        e.edge_idx = edge_n + n;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge sclk);
      rst    = 1'b0;
      ss     = 1'b0;
      outbuf = 8'($urandom);
      mosi   = 1'($urandom);
      #1;
      chk("miso_idle", miso, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat [6];
    pat = '{8'hA5, 8'h5A, 8'hAA, 8'hCC, 8'h0F, 8'hF0};
    rst = 1'b1; ss = 1'b0; mosi = 1'b0; outbuf = 8'h00;
    repeat (2) @(negedge sclk);
    rst = 1'b0;
    #1;
    chk("rst_buffer_in", buffer_in, 8'h00);
    chk("rst_ready_in", ready_in, 0);
    chk("rst_read", read, 0);
    chk("rst_miso", miso, 0);
    idle(4);

    drive_frame(8'hA5, 8, 1'b1, 8'h00, 1'b1);
    idle(3);

    for (int i = 0; i < 6; i++) drive_frame(pat[i], 8, 1'b1, 8'h00, 1'b1);
    idle(3);

    for (int i = 0; i < 20; i++) begin
      drive_frame(8'($urandom), 8, 1'($urandom), 8'($urandom), 1'b1);
      idle($urandom_range(0, 2));
    end
    idle(3);

    drive_frame(8'h3C, 4, 1'b1, 8'h00, 1'b0);
    drive_frame(8'hC3, 8, 1'b1, 8'h00, 1'b1);
    idle(3);

    drive_frame(8'h81, 5, 1'b1, 8'h00, 1'b0);
    @(negedge sclk);
    rst = 1'b1;
    ss  = 1'b0;
    @(negedge sclk);
    rst = 1'b0;
    #1;
    chk("abort_buffer_in", buffer_in, 8'h00);
    chk("abort_miso", miso, 0);
    drive_frame(8'h7E, 8, 1'b1, 8'h00, 1'b1);
    idle(3);

    drive_frame(8'h01, 8, 1'b1, 8'h00, 1'b1);
    idle(3);

    chk("pending", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
